// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a show-ahead FIFO and emits its words as valid/ready bursts with a last marker,
// full-length bursts when the FIFO holds a burst, short drain bursts on flush or idle timeout.
module fifo_burst_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] fifo_dout_i,
    input  logic             fifo_e_i,
    input  logic             fifo_ae_i,
    output logic             fifo_re_o,
    input  logic             flush_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o,
    output logic             busy_o
);
    localparam int PW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pop_cnt;
    logic [TW-1:0] to_cnt;
    logic          last_q;
    logic          hs;
    logic          done;
    logic          final_issued;

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (!fifo_ae_i && !fifo_e_i) ? BURST :
                       (!fifo_e_i && (flush_i || to_cnt == TW'(TIMEOUT - 1))) ? DRAIN : IDLE;
        else if (done)
            state_nx = IDLE;
    end

    // In DRAIN the held word becomes last as soon as the FIFO is seen empty behind it
    always_comb begin
        busy_o       = state != IDLE;
        m_last_o     = last_q | (state == DRAIN && m_valid_o && fifo_e_i);
        hs           = m_valid_o && m_ready_i;
        done         = hs && m_last_o;
        final_issued = (state == BURST) ? pop_cnt == PW'(BURST_LEN) : m_valid_o && m_last_o;
        fifo_re_o    = busy_o && !fifo_e_i && (!m_valid_o || m_ready_i) && !final_issued;
    end

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            last_q    <= 1'b0;
            pop_cnt   <= '0;
        end else if (done) begin
            m_valid_o <= 1'b0;
            last_q    <= 1'b0;
            pop_cnt   <= '0;
        end else if (fifo_re_o) begin
            m_data_o  <= fifo_dout_i;
            m_valid_o <= 1'b1;
            last_q    <= state == BURST && pop_cnt == PW'(BURST_LEN - 1);
            pop_cnt   <= pop_cnt + 1'b1;
        end else if (hs) begin
            m_valid_o <= 1'b0;
        end else if (m_valid_o) begin
            last_q    <= m_last_o;
        end

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) to_cnt <= '0;
        else to_cnt <= (state == IDLE && state_nx == IDLE && !fifo_e_i && fifo_ae_i) ? to_cnt + 1'b1 : '0;

endmodule
